// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronised buttons/tick, IDLE/RUN/PAUSE/LAP FSM, BCD mm:ss.t counter.
// Define STOPWATCH_LAP_EN to build the LAP state, the snapshot register and btn_lap handling.
module stopwatch_ctrl #(
  parameter int MAX_MINUTES = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       div_rst,
  output logic [3:0] tenths,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       lap_frozen,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
`ifdef STOPWATCH_LAP_EN
    , LAP = 2'd3
`endif
  } state_t;

  typedef struct packed {
    logic [2:0] mt;
    logic [3:0] mo;
    logic [2:0] st;
    logic [3:0] so;
    logic [3:0] t;
  } bcd_t;

  localparam logic [2:0] MAX_MT = 3'(MAX_MINUTES / 10);
  localparam logic [3:0] MAX_MO = 4'(MAX_MINUTES % 10);

  state_t state, state_nxt;
  bcd_t   cnt, cnt_nxt, inc, disp;
  logic   ovf_nxt, div_rst_nxt, at_max, counting;

  // Button history resets high so a button held through reset release is not an event
  logic [1:0] btn_s1, btn_s2, btn_prev;
  logic       clr_ev, ss_raw, ss_ev;
  logic       tick_s1, tick_s2, tick_prev, tick_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1    <= '1;
      btn_s2    <= '1;
      btn_prev  <= '1;
      tick_s1   <= 1'b0;
      tick_s2   <= 1'b0;
      tick_prev <= 1'b0;
    end else begin
      btn_s1    <= {btn_clear, btn_start_stop};
      btn_s2    <= btn_s1;
      btn_prev  <= btn_s2;
      tick_s1   <= tick_in;
      tick_s2   <= tick_s1;
      tick_prev <= tick_s2;
    end
  end

  assign clr_ev  = btn_s2[1] & ~btn_prev[1];
  assign ss_raw  = btn_s2[0] & ~btn_prev[0];
  assign ss_ev   = ss_raw & ~clr_ev;
  assign tick_ev = tick_s2 & ~tick_prev;

`ifdef STOPWATCH_LAP_EN
  logic lap_s1, lap_s2, lap_prev, lap_ev;
  bcd_t snap, snap_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_s1   <= 1'b1;
      lap_s2   <= 1'b1;
      lap_prev <= 1'b1;
    end else begin
      lap_s1   <= btn_lap;
      lap_s2   <= lap_s1;
      lap_prev <= lap_s2;
    end
  end

  assign lap_ev = lap_s2 & ~lap_prev & ~clr_ev & ~ss_raw;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      overflow <= 1'b0;
      div_rst  <= 1'b1;
`ifdef STOPWATCH_LAP_EN
      snap     <= '0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      overflow <= ovf_nxt;
      div_rst  <= div_rst_nxt;
`ifdef STOPWATCH_LAP_EN
      snap     <= snap_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ovf_nxt   = overflow;
    inc       = cnt;
`ifdef STOPWATCH_LAP_EN
    snap_nxt  = snap;
    counting  = (state == RUN) || (state == LAP);
`else
    counting  = (state == RUN);
`endif

    // BCD ripple increment
    if (cnt.t == 4'd9) begin
      inc.t = 4'd0;
      if (cnt.so == 4'd9) begin
        inc.so = 4'd0;
        if (cnt.st == 3'd5) begin
          inc.st = 3'd0;
          if (cnt.mo == 4'd9) begin
            inc.mo = 4'd0;
            inc.mt = cnt.mt + 3'd1;
          end else begin
            inc.mo = cnt.mo + 4'd1;
          end
        end else begin
          inc.st = cnt.st + 3'd1;
        end
      end else begin
        inc.so = cnt.so + 4'd1;
      end
    end else begin
      inc.t = cnt.t + 4'd1;
    end

    at_max = (cnt.mt == MAX_MT) && (cnt.mo == MAX_MO) && (cnt.st == 3'd5) &&
             (cnt.so == 4'd9) && (cnt.t == 4'd9);

    if (counting && tick_ev) begin
      if (at_max) ovf_nxt = 1'b1;
      else        cnt_nxt = inc;
    end

    case (state)
      IDLE: begin
        if (ss_ev) state_nxt = RUN;
      end
      RUN: begin
        if (ss_ev) state_nxt = PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (lap_ev) begin
          state_nxt = LAP;
          snap_nxt  = cnt;
        end
`endif
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (ss_ev)       state_nxt = PAUSE;
        else if (lap_ev) state_nxt = RUN;
      end
`endif
      PAUSE: begin
        if (clr_ev) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
`ifdef STOPWATCH_LAP_EN
          snap_nxt  = '0;
`endif
        end else if (ss_ev) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Saturation overrides any button-driven transition
    if (counting && tick_ev && at_max) state_nxt = PAUSE;

`ifdef STOPWATCH_LAP_EN
    div_rst_nxt = !((state_nxt == RUN) || (state_nxt == LAP));
`else
    div_rst_nxt = (state_nxt != RUN);
`endif
  end

`ifdef STOPWATCH_LAP_EN
  assign disp       = (state == LAP) ? snap : cnt;
  assign running    = (state == RUN) || (state == LAP);
  assign lap_frozen = (state == LAP);
`else
  assign disp       = cnt;
  assign running    = (state == RUN);
  assign lap_frozen = 1'b0;
`endif

  assign min_tens = disp.mt;
  assign min_ones = disp.mo;
  assign sec_tens = disp.st;
  assign sec_ones = disp.so;
  assign tenths   = disp.t;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Table-driven bench for stopwatch_ctrl; a second instance with MAX_MINUTES=0 covers saturation.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clear = 1'b0;

  logic       div_rst, running, lap_frozen, overflow;
  logic [3:0] tenths, sec_ones, min_ones;
  logic [2:0] sec_tens, min_tens;

  logic       z_div_rst, z_running, z_lap_frozen, z_overflow;
  logic [3:0] z_tenths, z_sec_ones, z_min_ones;
  logic [2:0] z_sec_tens, z_min_tens;

  int nChecks = 0;
  int nFail = 0;

  typedef enum {OP_RESET, OP_START, OP_LAP, OP_CLEAR, OP_TICKS, OP_SS_TICK, OP_CLR_SS} op_e;
  typedef struct {
    op_e op;
    int  n;
    int  expTime;
    bit  expRun;
    bit  expLap;
    bit  expOvf;
    bit  expDiv;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  stopwatch_ctrl dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .btn_start_stop(btn_start_stop),
    .btn_lap(btn_lap), .btn_clear(btn_clear), .div_rst(div_rst),
    .tenths(tenths), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .lap_frozen(lap_frozen), .overflow(overflow)
  );

  stopwatch_ctrl #(.MAX_MINUTES(0)) dut0 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .btn_start_stop(btn_start_stop),
    .btn_lap(btn_lap), .btn_clear(btn_clear), .div_rst(z_div_rst),
    .tenths(z_tenths), .sec_ones(z_sec_ones), .sec_tens(z_sec_tens),
    .min_ones(z_min_ones), .min_tens(z_min_tens),
    .running(z_running), .lap_frozen(z_lap_frozen), .overflow(z_overflow)
  );

  // Expected display digits {mt,mo,st,so,t} for a count given in tenths of a second
  function automatic logic [17:0] bcdOf(input int total);
    int m, s;
    m = total / 600;
    s = (total / 10) % 60;
    return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), 4'(total % 10)};
  endfunction

  function automatic void addVec(input op_e op, input int n, input int t,
                                 input bit r, input bit l, input bit o, input bit d);
    vec_t v;
    v.op = op; v.n = n; v.expTime = t;
    v.expRun = r; v.expLap = l; v.expOvf = o; v.expDiv = d;
    vecs.push_back(v);
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int expTime,
                             input bit er, input bit el, input bit eo, input bit ed);
    checkValue({name, ".disp"}, 32'({min_tens, min_ones, sec_tens, sec_ones, tenths}),
               32'(bcdOf(expTime)));
    checkValue({name, ".running"}, 32'(running), 32'(er));
    checkValue({name, ".lap_frozen"}, 32'(lap_frozen), 32'(el));
    checkValue({name, ".overflow"}, 32'(overflow), 32'(eo));
    checkValue({name, ".div_rst"}, 32'(div_rst), 32'(ed));
  endtask

  task automatic checkZero(input string name, input int expTime,
                           input bit er, input bit eo, input bit ed);
    checkValue({name, ".disp"}, 32'({z_min_tens, z_min_ones, z_sec_tens, z_sec_ones, z_tenths}),
               32'(bcdOf(expTime)));
    checkValue({name, ".running"}, 32'(z_running), 32'(er));
    checkValue({name, ".overflow"}, 32'(z_overflow), 32'(eo));
    checkValue({name, ".div_rst"}, 32'(z_div_rst), 32'(ed));
  endtask

  // which: 0 start_stop, 1 lap, 2 clear, 3 start_stop+tick, 4 clear+start_stop, 5 tick
  task automatic pulse(input int which);
    @(negedge clk);
    btn_start_stop = (which == 0) || (which == 3) || (which == 4);
    btn_lap        = (which == 1);
    btn_clear      = (which == 2) || (which == 4);
    tick_in        = (which == 3) || (which == 5);
    repeat (3) @(negedge clk);
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
    tick_in        = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) pulse(5);
  endtask

  task automatic applyStimulus(input vec_t v);
    case (v.op)
      OP_RESET:   doReset();
      OP_START:   pulse(0);
      OP_LAP:     pulse(1);
      OP_CLEAR:   pulse(2);
      OP_TICKS:   ticks(v.n);
      OP_SS_TICK: pulse(3);
      OP_CLR_SS:  pulse(4);
      default:    ;
    endcase
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    addVec(OP_RESET,    0,  0, 0, 0, 0, 1);
    addVec(OP_TICKS,    3,  0, 0, 0, 0, 1);
    addVec(OP_LAP,      0,  0, 0, 0, 0, 1);
    addVec(OP_CLEAR,    0,  0, 0, 0, 0, 1);
    addVec(OP_START,    0,  0, 1, 0, 0, 0);
    addVec(OP_TICKS,   25, 25, 1, 0, 0, 0);
    addVec(OP_CLEAR,    0, 25, 1, 0, 0, 0);
    addVec(OP_RESET,    0,  0, 0, 0, 0, 1);
    addVec(OP_START,    0,  0, 1, 0, 0, 0);
    addVec(OP_TICKS,   10, 10, 1, 0, 0, 0);
`ifdef STOPWATCH_LAP_EN
    addVec(OP_LAP,      0, 10, 1, 1, 0, 0);
    addVec(OP_TICKS,    7, 10, 1, 1, 0, 0);
    addVec(OP_CLEAR,    0, 10, 1, 1, 0, 0);
    addVec(OP_LAP,      0, 17, 1, 0, 0, 0);
`else
    addVec(OP_LAP,      0, 10, 1, 0, 0, 0);
    addVec(OP_TICKS,    7, 17, 1, 0, 0, 0);
    addVec(OP_LAP,      0, 17, 1, 0, 0, 0);
`endif
    addVec(OP_START,    0, 17, 0, 0, 0, 1);
    addVec(OP_TICKS,    4, 17, 0, 0, 0, 1);
    addVec(OP_LAP,      0, 17, 0, 0, 0, 1);
    addVec(OP_START,    0, 17, 1, 0, 0, 0);
    addVec(OP_TICKS,   43, 60, 1, 0, 0, 0);
    addVec(OP_START,    0, 60, 0, 0, 0, 1);
    addVec(OP_CLEAR,    0,  0, 0, 0, 0, 1);
    addVec(OP_START,    0,  0, 1, 0, 0, 0);
    addVec(OP_TICKS,    4,  4, 1, 0, 0, 0);
    addVec(OP_SS_TICK,  0,  5, 0, 0, 0, 1);
    addVec(OP_CLR_SS,   0,  0, 0, 0, 0, 1);
    addVec(OP_START,    0,  0, 1, 0, 0, 0);
    addVec(OP_TICKS,    2,  2, 1, 0, 0, 0);
`ifdef STOPWATCH_LAP_EN
    addVec(OP_LAP,      0,  2, 1, 1, 0, 0);
    addVec(OP_TICKS,    3,  2, 1, 1, 0, 0);
`else
    addVec(OP_LAP,      0,  2, 1, 0, 0, 0);
    addVec(OP_TICKS,    3,  5, 1, 0, 0, 0);
`endif
    addVec(OP_START,    0,  5, 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expTime, vecs[i].expRun,
                  vecs[i].expLap, vecs[i].expOvf, vecs[i].expDiv);
    end

    // Event latency: acted on at the second edge after the first sampling edge
    doReset();
    @(negedge clk);
    btn_start_stop = 1'b1;
    @(negedge clk);
    checkValue("lat.edge1.running", 32'(running), 32'd0);
    @(negedge clk);
    checkValue("lat.edge2.running", 32'(running), 32'd0);
    @(negedge clk);
    checkValue("lat.edge3.running", 32'(running), 32'd1);
    checkValue("lat.edge3.div_rst", 32'(div_rst), 32'd0);
    btn_start_stop = 1'b0;
    repeat (3) @(negedge clk);

    // Button held across reset release produces no event
    btn_start_stop = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkValue("held.running", 32'(running), 32'd0);
    btn_start_stop = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-count
    pulse(0);
    ticks(5);
    checkOutput("pre_rst", 5, 1, 0, 0, 0);
    @(negedge clk);
    tick_in = 1'b1;
    #2 rst = 1'b1;
    #1 checkOutput("async_rst", 0, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("post_rst", 0, 0, 0, 0, 1);

    // Saturation at MAX_MINUTES=0 and minute carry on the default instance
    doReset();
    pulse(0);
    ticks(599);
    checkZero("sat.599", 599, 1, 0, 0);
    checkOutput("main.599", 599, 1, 0, 0, 0);
    ticks(1);
    checkZero("sat.600", 599, 0, 1, 1);
    checkOutput("main.600", 600, 1, 0, 0, 0);
    ticks(1);
    checkZero("sat.601", 599, 0, 1, 1);
    checkOutput("main.601", 601, 1, 0, 0, 0);
    pulse(2);
    checkZero("sat.clear", 0, 0, 0, 1);
    checkOutput("main.clear", 601, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
